// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the instruction fetch unit and the control decoder:
// primary opcode constants and the fetch FSM state encoding.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_EXEC = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc
// Combinational next-PC selection for the fetch unit.
// Ports:
//   pc      in  32  address of the current instruction
//   instr   in  32  current instruction word
//   zero    in  1   ALU zero flag (only meaningful for BEQ)
//   next_pc out 32  address of the following instruction
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;
  logic [31:0] br_offset;
  logic [5:0]  op;

  assign op        = instr[31:26];
  assign pc4       = pc + 32'd4;
  // Word offset sign-extended and scaled to bytes; the add wraps modulo 2^32.
  assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc4;
    if (op == OP_J) begin
      next_pc = {pc4[31:28], instr[25:0], 2'b00};
    end else if ((op == OP_BEQ) && zero) begin
      next_pc = pc4 + br_offset;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch
// Two-state instruction fetch unit: requests the word at pc, registers it,
// holds it for decode until the datapath signals completion, then advances pc.
// Ports:
//   clk         in  1   system clock, rising edge
//   rst         in  1   asynchronous active-high reset
//   mem_req     out 1   instruction memory read request
//   mem_addr    out 32  request byte address (equals pc)
//   mem_ack     in  1   mem_rdata valid this cycle
//   mem_rdata   in  32  instruction word from memory
//   exec_done   in  1   datapath finished current instruction
//   zero        in  1   ALU zero flag, used with exec_done
//   pc          out 32  address of current instruction
//   instr       out 32  registered instruction word
//   op          out 6   instr[31:26]
//   funct       out 6   instr[5:0]
//   instr_valid out 1   instr/op/funct valid for decode
//
// state | meaning
// REQ   | request outstanding at pc, waiting for mem_ack
// EXEC  | instr held for decode, waiting for exec_done
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        exec_done,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  next_pc;
  logic         capture;
  logic         advance;

  next_pc_calc u_next_pc (
    .pc      (pc_q),
    .instr   (instr_q),
    .zero    (zero),
    .next_pc (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (capture) instr_q <= mem_rdata;
      if (advance) pc_q    <= next_pc;
    end
  end

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    advance     = 1'b0;
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      ST_REQ: begin
        // Gated with rst so the request drops the moment reset asserts.
        mem_req = ~rst;
        if (mem_ack) begin
          capture = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          advance = 1'b1;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign op       = instr_q[31:26];
  assign funct    = instr_q[5:0];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the address of the first fetched instruction after reset.
REQ-002 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 mem_req  out  1  instruction-memory read request.
REQ-005 mem_addr  out  32  byte address of the request; always equals pc.
REQ-006 mem_ack  in  1  memory has mem_rdata valid this cycle.
REQ-007 mem_rdata  in  32  instruction word returned by memory.
REQ-008 exec_done  in  1  datapath has finished the current instruction.
REQ-009 zero  in  1  ALU zero flag; sampled only together with exec_done.
REQ-010 pc  out  32  address of the current instruction.
REQ-011 instr  out  32  registered instruction word.
REQ-012 op  out  6  instr[31:26], driven to the control decoder.
REQ-013 funct  out  6  instr[5:0], driven to the control decoder.
REQ-014 instr_valid  out  1  instr/op/funct are valid for decode.

Function
REQ-015 The FSM SHALL have two states: REQ and EXEC.
REQ-016 In REQ: mem_req=1, instr_valid=0; mem_req SHALL stay high until a rising edge samples mem_ack=1.
REQ-017 REQ with mem_ack=1 at an edge: instr<=mem_rdata and state<=EXEC.
REQ-018 A same-cycle ack SHALL be legal, giving minimum latency of 1 cycle from mem_req to instr_valid.
REQ-019 In EXEC: mem_req=0, instr_valid=1; instr, pc and state SHALL hold while exec_done=0.
REQ-020 EXEC with exec_done=1 at an edge: pc<=next_pc and state<=REQ, for a minimum of 2 cycles per instruction.
REQ-021 next_pc, with pc4 = pc+4 modulo 2^32:
  - op=J (000010): {pc4[31:28], instr[25:0], 2'b00}.
  - op=BEQ (000100) and zero=1: pc4 + (sign-extended instr[15:0] << 2), modulo 2^32.
  - any other op, including BEQ with zero=0: pc4.
REQ-022 Opcodes without branch or jump semantics (R, ADDI, LW, SW, unknown) SHALL advance by pc4; no trap.
REQ-023 mem_ack outside REQ and exec_done outside EXEC SHALL be ignored.
REQ-024 zero SHALL be ignored unless op=BEQ and exec_done=1 in EXEC.
REQ-025 Wrap-around: pc=32'hFFFF_FFFC with a sequential instruction SHALL give next pc 32'h0000_0000.
REQ-026 A negative branch offset SHALL be legal; offset 16'hFFFF SHALL branch to self.

Reset
REQ-027 rst=1 SHALL force, asynchronously: state=REQ, pc=RESET_PC, instr=0, instr_valid=0.
REQ-028 During rst, mem_req SHALL be 0; op and funct SHALL be 0.
REQ-029 rst during an outstanding request SHALL abandon it; a late mem_ack SHALL not be captured.
REQ-030 The first edge after rst deasserts SHALL present mem_req=1 with mem_addr=RESET_PC.

Structure
REQ-031 Opcode constants (OP_R, OP_J, OP_ADDI, OP_BEQ, OP_LW, OP_SW) and the FSM state encoding SHALL live in shared package mips_pkg, also used by the control decoder.
REQ-032 next-PC arithmetic SHALL be one combinational sub-module, next_pc_calc (inputs pc, instr, zero; output next_pc).

Verification
REQ-033 Sequential fetch: reset, memory ack latency 0 and then 3 cycles, exec_done after 1 cycle -> mem_addr sequence 0, 4, 8; instr_valid high only in EXEC.
REQ-034 Taken branch: at pc=0x10, BEQ with imm=0xFFFE and zero=1 -> next mem_addr 0x0C; with zero=0 -> 0x14.
REQ-035 Jump: at pc=0x8000_0000, J with target 26'h0000010 -> next mem_addr 0x8000_0040.
REQ-036 Wrap-around: RESET_PC=0xFFFF_FFFC, ADD instruction -> next mem_addr 0x0000_0000.
REQ-037 Reset mid-fetch: assert rst while mem_req=1, then release; an ack arriving during rst -> instr stays 0, refetch from RESET_PC.
REQ-038 Spurious inputs: exec_done pulsed in REQ and mem_ack pulsed in EXEC -> pc, instr and state unchanged.
